fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

- Shares the asynchronous FIFO's write port between `NUM_REQ` requesters in the write clock domain.
- Arbitration is round-robin. The winner holds a burst grant of up to `MAX_BURST` words.
- The block drives the FIFO's `wr_en`/`data_in` and honours `full` back-pressure with a same-cycle per-word acknowledge.
- It sits between producer blocks and the FIFO's write side; the read side is untouched.

## Interface

Parameters:

- `NUM_REQ`, 4: number of requesters; a power of two, ≥2.
- `MAX_BURST`, 4: maximum words accepted per grant; ≥1.
- `DATA_WIDTH`, from package (8): FIFO word width.

Ports:

- `clk_wr` in 1: the only clock, the FIFO write clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: per-requester word-valid; held high while data is offered.
- `req_data` in `NUM_REQ`×`DATA_WIDTH`: per-requester word, packed with requester *i* at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack` out `NUM_REQ`: word from requester *i* accepted this cycle.
- `grant` out `NUM_REQ`: one-hot registered owner; all zero when idle.
- `full` in 1: FIFO full, write-domain flag.
- `wr_en` out 1: FIFO write enable.
- `data_in` out `DATA_WIDTH`: FIFO write data.
- `busy` out 1: a grant is held.

## Operation

- The state machine has two states, `IDLE` and `BURST`.
  - Registered state: `owner` (log2 NUM_REQ bits), `rr_ptr` (log2 NUM_REQ bits), and `burst_cnt` (log2 MAX_BURST + 1 bits).
- **IDLE**
  - If `req` is non-zero, the block picks the first set bit searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - It loads `owner`, clears `burst_cnt`, and goes to `BURST` at the next edge.
  - If `req` is zero, it stays in `IDLE`.
- **BURST**, word acceptance:
  - `accept` = `req[owner] & ~full`.
  - `wr_en` = `accept`.
  - `ack` = `accept` one-hot at `owner`.
  - `data_in` = `req_data[owner]`.
  - On `accept`, `burst_cnt` increments.
- **BURST**, release: the grant is released at an edge when either condition holds:
  - `accept && burst_cnt == MAX_BURST-1`, i.e. the final word; or
  - `req[owner] == 0` (requester withdrew).
- On release:
  - `rr_ptr` becomes `owner+1`, modulo `NUM_REQ`.
  - In the same edge, the next owner is picked from the current `req` with `owner` masked off, searching from `owner+1`. That owner is loaded directly into `BURST` with no bubble.
  - If no other requester is pending but `owner` still requests (burst limit hit), `owner` regains the grant.
  - If nothing is pending, the state goes to `IDLE`.
- **`full` handling**
  - While `full=1`: no `accept`, `burst_cnt` holds, and the grant is held, because `full` alone never releases it.
  - A `req[owner]` drop while `full` still releases the grant.
- **Outputs in `IDLE`**: `grant`, `ack`, `wr_en` and `busy` are 0, and `data_in` is 0.
  - `data_in` is a gated mux, so it is 0 whenever not in `BURST`.
- **Requester rule**: a requester must not change `req_data` while `req=1` and `ack=0`. The arbiter does not check this.
- **Reset**
  - Values: state `IDLE`, `owner=0`, `rr_ptr=0`, `burst_cnt=0`.
  - All outputs are 0 from the first edge with `rst=1`.
  - A mid-burst reset drops the grant; words not yet acked are discarded, not written.

## Timing

- Arbitration latency: `req` rising in `IDLE` at edge *n* → `grant` and the first possible `wr_en` in cycle *n+1*.
- Back-to-back grants between different owners have zero dead cycles.
- Throughput is one word per `clk_wr` while the owner requests and `full=0`.
- `wr_en`, `ack` and `data_in` are combinational from registered state and the `req`/`full` inputs. There is no added pipeline delay, so `full` back-pressure is exact and the FIFO never sees `wr_en` while `full`.
- `grant` and `busy` are purely registered.

## Structure

- `Asynchronous_FIFO_pkg` gains:
  - `NUM_REQ` and `MAX_BURST` defaults;
  - the `arb_state_t` enum (`IDLE`, `BURST`);
  - a `REQ_IDX_W = $clog2(NUM_REQ)` constant.
- One sub-module, `fifo_wr_rr_pick`: combinational rotate-and-priority-encode.
  - Inputs: `req`, start index, mask.
  - Outputs: `found` and the winner index.
  - It is instantiated once and used for both the `IDLE` pick and the release pick.

## Test plan

All scenarios use `NUM_REQ=4`, `MAX_BURST=4`.

- **Reset**: assert `rst` mid-burst with `req=4'b0011` → next cycle `grant=0`, `wr_en=0`, `busy=0`, `data_in=0`. After deassert, requester 0 is granted first (`rr_ptr=0`).
- **Single requester burst**: `req=4'b0100` held, data 0x10, 0x11, … → `grant=4'b0100` one cycle after `req`. Four `ack`s, then the grant is released and immediately re-granted to requester 2, giving 8 consecutive `wr_en` over two bursts.
- **Round-robin fairness**: `req=4'b1111` continuously → grant order 0,1,2,3,0, with exactly 4 words each and `wr_en` high every cycle after the first.
- **Back-pressure**: requester 1 in burst, `full` forced high for 3 cycles after 2 words → `wr_en=0` and `ack=0` during those cycles, grant held. Resume yields exactly 2 more words, total 4.
- **Early withdrawal**: requester 3 drops `req` after 1 word while `req[0]=1` → grant moves to requester 0 at that edge, and the next owner search starts at index 0.
- **Simultaneous full and withdraw**: owner drops `req` while `full=1` → grant released, no `wr_en` asserted in any cycle with `full=1`.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and types for the asynchronous FIFO write-side arbiter.
//   DATA_WIDTH    : FIFO word width
//   NUM_REQ_DEF   : default number of write requesters
//   MAX_BURST_DEF : default maximum words per grant
//   REQ_IDX_W     : requester index width at the default requester count
//   arb_state_t   : arbiter FSM states
package Asynchronous_FIFO_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned REQ_IDX_W     = $clog2(NUM_REQ_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the arbiter and the FIFO write port.
//   master : arbiter view (takes requests/full, drives ack/grant/wr_en/data_in/busy)
//   slave  : producer/FIFO view (the opposite directions)
interface fifo_wr_arbiter_if
  import Asynchronous_FIFO_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          busy;

  modport master (
    input  req, req_data, full,
    output ack, grant, wr_en, data_in, busy
  );

  modport slave (
    output req, req_data, full,
    input  ack, grant, wr_en, data_in, busy
  );

endinterface

// File: rtl/fifo_wr_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~mask), searching
// upward from start and wrapping modulo NUM_REQ (NUM_REQ is a power of two).
//   req   : candidate requests
//   start : index where the search begins
//   mask  : requesters excluded from this pick
//   found : some unmasked request exists
//   idx   : winning requester index
module fifo_wr_rr_pick
  import Asynchronous_FIFO_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  input  logic [NUM_REQ-1:0]         mask,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] avail;
  logic [IDX_W-1:0]   cand;

  assign avail = req & ~mask;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // Index arithmetic wraps naturally because NUM_REQ is a power of two.
      cand = start + k[IDX_W-1:0];
      if (!found && avail[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ
// producers in the write clock domain.
//   clk_wr : FIFO write clock (only clock)
//   rst    : synchronous active-high reset
//   bus    : master modport -- req/req_data/full in; ack/grant/wr_en/data_in/busy out
module fifo_wr_arbiter
  import Asynchronous_FIFO_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk_wr,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;

  logic               in_burst;
  logic               owner_req;
  logic               accept;
  logic               release_grant;
  logic [NUM_REQ-1:0] owner_oh;
  logic [IDX_W-1:0]   owner_nxt;
  logic [IDX_W-1:0]   pick_start;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  assign in_burst      = (state == BURST);
  assign owner_req     = bus.req[owner];
  assign accept        = in_burst & owner_req & ~bus.full;
  assign owner_nxt     = owner + 1'b1;
  // full alone never ends a burst: only the final accepted word or a withdrawal.
  assign release_grant = in_burst & ((accept & (burst_cnt == LAST_CNT)) | ~owner_req);

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // One picker serves both the IDLE pick and the release hand-over.
  assign pick_start = in_burst ? owner_nxt : rr_ptr;
  assign pick_mask  = in_burst ? owner_oh : '0;

  fifo_wr_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (bus.req),
    .start (pick_start),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_wr) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= BURST;
            owner     <= pick_idx;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          if (release_grant) begin
            rr_ptr    <= owner_nxt;
            burst_cnt <= '0;
            if (pick_found) begin
              owner <= pick_idx;
            end else if (!owner_req) begin
              state <= IDLE;
            end
            // else: burst limit hit with no competitor, owner keeps the grant.
          end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en   = accept;
  assign bus.ack     = accept ? owner_oh : '0;
  assign bus.grant   = in_burst ? owner_oh : '0;
  assign bus.busy    = in_burst;
  assign bus.data_in = in_burst ? bus.req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  import Asynchronous_FIFO_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] ack;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic        full = 1'b0;
  logic [31:0] rd;
  int          cnt [4];

  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [3:0]  g_s, a_s;
  logic        b_s, w_s;
  logic [7:0]  d_s;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .clk_wr (clk),
    .rst    (rst),
    .bus    (bus.master)
  );

  // Requester i offers {i, cnt[i][5:0]}; cnt advances only on its ack.
  always_comb begin
    rd = '0;
    for (int i = 0; i < 4; i++) rd[i*8 +: 8] = {i[1:0], cnt[i][5:0]};
  end

  assign bus.req      = req;
  assign bus.req_data = rd;
  assign bus.full     = full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input int r, input int c);
    exp_t e;
    e.data = {r[1:0], c[5:0]};
    e.ack  = 4'(1 << r);
    sb.push_back(e);
  endtask

  // Sample and score at negedge, then advance requester data after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    g_s = bus.grant;
    b_s = bus.busy;
    w_s = bus.wr_en;
    d_s = bus.data_in;
    a_s = bus.ack;
    if (full) check("no_wr_when_full", 32'(w_s), 32'd0);
    if (w_s) begin
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("data_in", 32'(d_s), 32'(e.data));
        check("ack", 32'(a_s), 32'(e.ack));
      end
    end else begin
      check("ack_without_wr", 32'(a_s), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (a_s[i]) cnt[i]++;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    full = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cnt[i] = 0;

    // Reset state and mid-burst reset
    cycle();
    check("rst_grant", 32'(g_s), 32'd0);
    check("rst_busy", 32'(b_s), 32'd0);
    check("rst_wr_en", 32'(w_s), 32'd0);
    check("rst_data_in", 32'(d_s), 32'd0);
    rst = 1'b0;
    req = 4'b0011;
    for (int c = 0; c < 3; c++) push_word(0, c);
    cycle();
    check("arb_latency_idle", 32'(g_s), 32'd0);
    cycle();
    check("first_grant_r0", 32'(g_s), 32'b0001);
    cycle();
    rst = 1'b1;
    cycle();                         // reset sampled at the end of this cycle
    cycle();
    check("midrst_grant", 32'(g_s), 32'd0);
    check("midrst_wr_en", 32'(w_s), 32'd0);
    check("midrst_busy", 32'(b_s), 32'd0);
    check("midrst_data_in", 32'(d_s), 32'd0);
    rst = 1'b0;
    push_word(0, 3);
    cycle();
    cycle();
    check("post_rst_grant_r0", 32'(g_s), 32'b0001);
    req = '0;
    cycle();
    cycle();
    check("withdraw_idle_busy", 32'(b_s), 32'd0);
    check("sb_empty_reset", 32'(sb.size()), 32'd0);

    // Single requester: two back-to-back bursts, eight consecutive writes
    do_reset();
    cnt[2] = 16;
    req = 4'b0100;
    for (int c = 16; c < 24; c++) push_word(2, c);
    cycle();
    check("single_idle_grant", 32'(g_s), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("single_grant", 32'(g_s), 32'b0100);
      check("single_wr_en", 32'(w_s), 32'd1);
    end
    req = '0;
    cycle();
    cycle();
    check("single_release", 32'(g_s), 32'd0);
    check("sb_empty_single", 32'(sb.size()), 32'd0);

    // Round-robin fairness: 0,1,2,3,0 with four words each
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) push_word((k / 4) % 4, (k % 4) + ((k >= 16) ? 4 : 0));
    cycle();
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("rr_grant", 32'(g_s), 32'(1 << ((k / 4) % 4)));
      check("rr_wr_en", 32'(w_s), 32'd1);
    end
    req = '0;
    cycle();
    cycle();
    check("rr_idle", 32'(b_s), 32'd0);
    check("sb_empty_rr", 32'(sb.size()), 32'd0);

    // Back-pressure: 2 words, full for 3 cycles, 2 more words
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 4; c++) push_word(1, c);
    cycle();
    cycle();
    cycle();
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_grant_held", 32'(g_s), 32'b0010);
      check("bp_ack", 32'(a_s), 32'd0);
    end
    full = 1'b0;
    cycle();
    cycle();
    check("bp_words_left", 32'(sb.size()), 32'd0);
    req = '0;
    cycle();
    cycle();
    check("bp_wr_after", 32'(w_s), 32'd0);
    check("bp_cnt_r1", 32'(cnt[1]), 32'd4);

    // Early withdrawal of requester 3 hands over to requester 0 at that edge
    do_reset();
    req = 4'b1000;
    push_word(3, 0);
    cycle();
    cycle();
    check("ew_grant_r3", 32'(g_s), 32'b1000);
    req = 4'b0001;
    for (int c = 0; c < 4; c++) push_word(0, c);
    cycle();
    check("ew_withdraw_grant", 32'(g_s), 32'b1000);
    check("ew_withdraw_wr", 32'(w_s), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("ew_grant_r0", 32'(g_s), 32'b0001);
      check("ew_wr_en", 32'(w_s), 32'd1);
    end
    req = '0;
    cycle();
    cycle();
    check("sb_empty_ew", 32'(sb.size()), 32'd0);

    // Simultaneous full and withdrawal
    do_reset();
    req = 4'b0100;
    push_word(2, 0);
    cycle();
    cycle();
    full = 1'b1;
    cycle();
    check("fw_grant_held", 32'(g_s), 32'b0100);
    req = '0;
    cycle();
    check("fw_release_cycle_grant", 32'(g_s), 32'b0100);
    cycle();
    check("fw_released_grant", 32'(g_s), 32'd0);
    check("fw_released_busy", 32'(b_s), 32'd0);
    full = 1'b0;
    cycle();
    check("sb_empty_fw", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
